// File: rtl/onewire_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_pkg
//  Description : Shared 1-Wire definitions: bit-slot state encoding and the
//                default slot timing (in clock cycles) used by the byte engine
//                and the reset/presence block.
//  Revision    : 1.0 - initial release
// ============================================================================
package onewire_pkg;

    // Bit-slot engine states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOW     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_REC     = 2'd3
    } ow_state_t;

    // Default slot timing, in clock cycles
    localparam int c_T_SLOT   = 60;   // slot length from start of low pulse
    localparam int c_T_LOW0   = 60;   // low time for a write-0
    localparam int c_T_LOW1   = 6;    // low time for a write-1 / read slot
    localparam int c_T_SAMPLE = 14;   // read sample point (incl. synchroniser)
    localparam int c_T_REC    = 11;   // recovery after each slot
    localparam int c_T_RSTL   = 480;  // reset pulse low time
    localparam int c_T_PDWAIT = 70;   // wait before sampling presence

endpackage
`default_nettype wire

// File: rtl/onewire_sync.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_sync
//  Description : Two-flop synchroniser bringing the asynchronous open-drain
//                bus level into the clk domain. Resets to the idle (released,
//                high) bus level so no false low is seen after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module onewire_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the raw bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/onewire_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_byte_engine
//  Description : 1-Wire bit-slot engine. Writes tx_data or reads NBITS bits,
//                LSB first, with cycle-programmable slot timing. Drives the
//                pad's open-drain enable and samples the synchronised bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module onewire_byte_engine
    import onewire_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int T_SLOT   = c_T_SLOT,
    parameter int T_LOW0   = c_T_LOW0,
    parameter int T_LOW1   = c_T_LOW1,
    parameter int T_SAMPLE = c_T_SAMPLE,
    parameter int T_REC    = c_T_REC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rd_mode,
    input  logic [NBITS-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rx_data,
    output logic             master_pull_low,
    input  logic             bus
);

    // The slot counter covers both the slot and the recovery phase
    localparam int c_SC_MAX = (T_SLOT > T_REC) ? T_SLOT : T_REC;
    localparam int c_SC_W   = (c_SC_MAX > 1) ? $clog2(c_SC_MAX) : 1;
    localparam int c_BI_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [c_SC_W-1:0] c_SLOT_LAST = c_SC_W'(T_SLOT - 1);
    localparam logic [c_SC_W-1:0] c_LOW0_LAST = c_SC_W'(T_LOW0 - 1);
    localparam logic [c_SC_W-1:0] c_LOW1_LAST = c_SC_W'(T_LOW1 - 1);
    localparam logic [c_SC_W-1:0] c_SAMPLE_AT = c_SC_W'(T_SAMPLE);
    localparam logic [c_SC_W-1:0] c_REC_LAST  = c_SC_W'(T_REC - 1);
    localparam logic [c_BI_W-1:0] c_BI_LAST   = c_BI_W'(NBITS - 1);
    // A write-0 that fills the whole slot skips the RELEASE phase
    localparam logic              c_LOW0_FULL = (T_LOW0 == T_SLOT);

    ow_state_t          r_state;
    ow_state_t          w_state_nxt;
    logic [c_SC_W-1:0]  r_sc;
    logic [c_BI_W-1:0]  r_bi;
    logic [NBITS-1:0]   r_tx_shift;
    logic [NBITS-1:0]   r_rx_shift;
    logic [NBITS-1:0]   r_rx_data;
    logic [NBITS-1:0]   w_rx_shifted;
    logic               r_rd_mode;
    logic               r_mpl;
    logic               r_done;
    logic               w_bus_sync;
    logic               w_accept;
    logic               w_sc_clr;
    logic               w_next_bit;
    logic               w_finish;
    logic               w_write0;
    logic [c_SC_W-1:0]  w_tlow_last;
    logic               w_sample;

    onewire_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus),
        .o_sync  (w_bus_sync)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slot-counter control
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sc_clr    = 1'b0;
        w_next_bit  = 1'b0;
        w_finish    = 1'b0;
        w_write0    = !r_rd_mode && !r_tx_shift[0];
        w_tlow_last = w_write0 ? c_LOW0_LAST : c_LOW1_LAST;
        case (r_state)
            ST_IDLE: begin
                w_sc_clr = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (r_sc == w_tlow_last) begin
                    if (w_write0 && c_LOW0_FULL) begin
                        w_state_nxt = ST_REC;
                        w_sc_clr    = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (r_sc == c_SLOT_LAST) begin
                    w_state_nxt = ST_REC;
                    w_sc_clr    = 1'b1;
                end
            end
            ST_REC: begin
                if (r_sc == c_REC_LAST) begin
                    w_sc_clr = 1'b1;
                    if (r_bi == c_BI_LAST) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_next_bit  = 1'b1;
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sc_clr    = 1'b1;
            end
        endcase
    end

    // Read sample point sits inside the slot, past the end of the low pulse
    assign w_sample     = r_rd_mode && (r_state == ST_LOW || r_state == ST_RELEASE)
                          && (r_sc == c_SAMPLE_AT);
    // LSB-first reception: new bit enters at the MSB, word shifts right
    assign w_rx_shifted = (r_rx_shift >> 1) | (NBITS'(w_bus_sync) << (NBITS - 1));

    // Datapath: slot counter, shift registers, registered bus drive and done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc       <= '0;
            r_bi       <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rd_mode  <= 1'b0;
            r_mpl      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sc   <= w_sc_clr ? '0 : r_sc + c_SC_W'(1);
            r_mpl  <= (w_state_nxt == ST_LOW);
            r_done <= w_finish;
            if (w_accept) begin
                r_tx_shift <= tx_data;
                r_rd_mode  <= rd_mode;
                r_bi       <= '0;
            end else if (w_next_bit) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_bi       <= r_bi + c_BI_W'(1);
            end
            if (w_sample) begin
                r_rx_shift <= w_rx_shifted;
            end
            if (w_finish && r_rd_mode) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign done            = r_done;
    assign rx_data         = r_rx_data;
    assign master_pull_low = r_mpl;

endmodule
`default_nettype wire

// File: doc/onewire_byte_engine.md
# onewire_byte_engine

Parametrised 1-Wire bit-slot engine that writes or reads an NBITS-wide word, LSB first, over an open-drain bus. It generalises the fixed Skip-ROM command sender into a generic transfer engine. Slot timing is set in clock cycles, and read slots sample the bus. It sits between the 1-Wire transaction controller (reset/presence, ROM and function commands) and the pad's open-drain driver.

## Interface
Parameters:
- NBITS, 8, bits per transfer (1..64)
- T_SLOT, 60, slot length in cycles, measured from the start of the low pulse
- T_LOW0, 60, low time for a write-0; T_LOW0 <= T_SLOT
- T_LOW1, 6, low time for a write-1 and for a read slot; T_LOW1 < T_SAMPLE
- T_SAMPLE, 14, slot cycle at which the synchronised bus is sampled; includes the 2-cycle synchroniser latency; T_SAMPLE < T_SLOT
- T_REC, 11, recovery cycles after each slot, bus released; >= 1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a transfer; accepted only when busy=0
- rd_mode  in  1  0 = write tx_data, 1 = read NBITS bits; captured with start
- tx_data  in  NBITS  data to write; captured with start
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at the end of a transfer
- rx_data  out  NBITS  last completed read word; holds until the next read completes
- master_pull_low  out  1  1 = drive the bus low, 0 = release; registered
- bus  in  1  raw bus level, asynchronous

## Operation
- States: IDLE, LOW, RELEASE, REC. A slot counter (sc) runs 0..T_SLOT-1 across LOW and RELEASE, then 0..T_REC-1 in REC. A bit index (bi) runs 0..NBITS-1.
- IDLE:
  - On start, capture tx_data into the shift register and latch rd_mode.
  - Clear sc and bi, then go to LOW.
- LOW:
  - master_pull_low=1.
  - Low time is tlow = T_LOW0 if writing a 0, otherwise T_LOW1.
  - When sc reaches tlow-1, go to RELEASE. If tlow = T_SLOT, go directly to REC.
- RELEASE:
  - master_pull_low=0.
  - When sc = T_SLOT-1, go to REC.
- Read sampling: in read mode, at sc = T_SAMPLE the synchronised bus bit is shifted into the receive register at the MSB, shifting right.
- REC:
  - master_pull_low=0.
  - When sc = T_REC-1: if bi = NBITS-1, return to IDLE, pulse done, and load rx_data (read mode only). Otherwise increment bi, shift tx right, and go to LOW.
- Write-1 and read slots are identical on the wire.
- Counter widths are $clog2 of the maximum count. No wrap is allowed inside a slot.

## Timing
- Reset values: master_pull_low=0, busy=0, done=0, rx_data=0. State goes to IDLE and the shift registers clear.
- Reset mid-transfer: the bus is released on the next edge. done does not pulse and rx_data keeps its reset value 0.
- start with busy=1 is ignored. tx_data and rd_mode changes while busy have no effect.
- Latency:
  - The first master_pull_low=1 is visible the cycle after start is sampled.
  - done asserts exactly NBITS*(T_SLOT+T_REC) cycles after that; with defaults this is 568.
- done and busy=0 coincide. A start in the done cycle is accepted, giving back-to-back transfers with no idle gap.
- rx_data updates in the same cycle as done.

## Structure
- Shared package onewire_pkg holds:
  - the state enum
  - default timing constants (T_SLOT, T_LOW0, T_LOW1, T_SAMPLE, T_REC, T_RSTL, T_PDWAIT), also used by the reset/presence block
- Sub-module onewire_sync: 2-flop bus synchroniser, reused by the reset/presence detector.

## Test plan
- Write 0xCC with defaults. master_pull_low is high for 60 cycles in slots 0, 1, 4, 5 and for 6 cycles in slots 2, 3, 6, 7. Each slot plus recovery is 71 cycles. done arrives 568 cycles after the first low.
- Read with a slave model returning 0xA5, holding the bus low through cycle 30 for 0 bits. Expect rx_data=0xA5 at done and 6-cycle low pulses in every slot.
- Pulse start during slot 3 of a write. There is no effect on the waveform, and there is exactly one done.
- Assert rst at slot 2, cycle 10. The next cycle shows master_pull_low=0, busy=0, done never pulses, and rx_data=0. A new start then works normally.
- Raise start in the done cycle with tx_data=0xFF. The next cycle is low; there are 8 slots of 6-cycle lows and no IDLE gap.
- NBITS=1, T_SLOT=20, T_LOW0=20, T_REC=1, write 0. master_pull_low is high for 20 cycles, then low for 1 cycle, then done.
